// File: rtl/atten_spi_loader.sv
// Serial loader for step attenuators: queues per-channel codes and shifts each out MSB first
// on a shared SCLK/SDATA bus, then pulses that channel's LE.
//
// state  | meaning
// IDLE   | bus quiet, waiting for a pending channel
// LOAD   | pick lowest pending channel, load shift register, present MSB
// SHIFT  | DW bits, SCLK low then high for CLK_DIV cycles each
// LATCH  | LE[ch] high for LE_W cycles
// GAP    | one-cycle DONE pulse, BUSY low
module atten_spi_loader #(
  parameter int N_CH    = 2,
  parameter int DW      = 6,
  parameter int CLK_DIV = 2,
  parameter int LE_W    = 2,
  parameter int INVERT  = 1,
  localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic            WR_EN,
  input  logic [CHW-1:0]  WR_CH,
  input  logic [DW-1:0]   WR_DATA,
  output logic            BUSY,
  output logic            DONE,
  output logic            SCLK,
  output logic            SDATA,
  output logic [N_CH-1:0] LE
);

  localparam int DIVW = $clog2(CLK_DIV + 1);
  localparam int BCW  = $clog2(DW + 1);
  localparam int LECW = $clog2(LE_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [DW-1:0]   shadow_q [N_CH];
  logic [DW-1:0]   shadow_d [N_CH];
  logic [DW-1:0]   sreg_q, sreg_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [BCW-1:0]  bit_q, bit_d;
  logic [LECW-1:0] lec_q, lec_d;
  logic            sclk_q, sclk_d;
  logic            sdata_q, sdata_d;
  logic [CHW-1:0]  sel;
  logic [DW-1:0]   code;
  logic            wr_ok;

  assign wr_ok = WR_EN && (int'(WR_CH) < N_CH);

  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = CHW'(i);
    end
  end

  assign code = (INVERT != 0) ? ~shadow_q[sel] : shadow_q[sel];

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    sreg_d   = sreg_q;
    div_d    = div_q;
    bit_d    = bit_q;
    lec_d    = lec_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    case (state_q)
      S_IDLE: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        if (|pend_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Channel is chosen here, not in IDLE, so a lower channel written one cycle late still wins.
        ch_d        = sel;
        sreg_d      = code;
        sdata_d     = code[DW-1];
        sclk_d      = 1'b0;
        div_d       = DIVW'(CLK_DIV - 1);
        bit_d       = BCW'(DW - 1);
        pend_d[sel] = 1'b0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = DIVW'(CLK_DIV - 1);
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == '0) begin
              sdata_d = 1'b0;
              lec_d   = LECW'(LE_W - 1);
              state_d = S_LATCH;
            end else begin
              bit_d   = bit_q - 1'b1;
              sreg_d  = sreg_q << 1;
              sdata_d = sreg_d[DW-1];
            end
          end
        end
      end
      S_LATCH: begin
        if (lec_q == '0) state_d = S_GAP;
        else             lec_d   = lec_q - 1'b1;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A same-edge write re-arms the channel even if LOAD is clearing it.
    if (wr_ok) begin
      shadow_d[WR_CH] = WR_DATA;
      pend_d[WR_CH]   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      pend_q  <= '0;
      for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
      sreg_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      lec_q   <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      sreg_q   <= sreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      lec_q    <= lec_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
    end
  end

  assign BUSY  = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_LATCH);
  assign DONE  = (state_q == S_GAP);
  assign SCLK  = sclk_q;
  assign SDATA = sdata_q;
  assign LE    = (state_q == S_LATCH) ? (N_CH'(1) << ch_q) : '0;

endmodule

// File: tb/tb_atten_spi_loader.sv
// Directed bench for atten_spi_loader: default build plus a 3-channel, non-inverting,
// CLK_DIV=1 build for the out-of-range write and fast-clock cases.
module tb_atten_spi_loader;

  logic       clk = 1'b0;
  logic       nrst, wr_en, wr_ch;
  logic [5:0] wr_data;
  logic       busy, done, sclk, sdata;
  logic [1:0] le;

  logic       nrst_b, wr_en_b;
  logic [1:0] wr_ch_b;
  logic [5:0] wr_data_b;
  logic       busy_b, done_b, sclk_b, sdata_b;
  logic [2:0] le_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  atten_spi_loader #(.N_CH(2), .DW(6), .CLK_DIV(2), .LE_W(2), .INVERT(1)) dut (
    .CLK(clk), .NRST(nrst), .WR_EN(wr_en), .WR_CH(wr_ch), .WR_DATA(wr_data),
    .BUSY(busy), .DONE(done), .SCLK(sclk), .SDATA(sdata), .LE(le));

  atten_spi_loader #(.N_CH(3), .DW(6), .CLK_DIV(1), .LE_W(2), .INVERT(0)) dut_b (
    .CLK(clk), .NRST(nrst_b), .WR_EN(wr_en_b), .WR_CH(wr_ch_b), .WR_DATA(wr_data_b),
    .BUSY(busy_b), .DONE(done_b), .SCLK(sclk_b), .SDATA(sdata_b), .LE(le_b));

  // Bus observers, sampled on the falling clock edge.
  int         ncyc = 0;
  int         busy_n = 0, done_n = 0, le0_n = 0, le1_n = 0, rise_n = 0, done_at = 0;
  int         bad_le = 0, bad_db = 0;
  logic [5:0] cap = '0;
  logic       sclk_p = 1'b0;
  logic [1:0] le_p = '0;
  logic [1:0] le_ev [$];
  logic [5:0] le_cap [$];

  int         busy_nb = 0, done_nb = 0, rise_nb = 0, done_atb = 0, rise_at_b = 0, rise_prev_b = 0;
  logic [5:0] capb = '0;
  logic       sclk_pb = 1'b0;
  logic [2:0] le_pb = '0;
  logic [2:0] le_ev_b [$];

  always @(negedge clk) begin
    ncyc++;
    busy_n += int'(busy);
    le0_n  += int'(le[0]);
    le1_n  += int'(le[1]);
    if (done) begin done_n++; done_at = ncyc; end
    if (sclk && !sclk_p) begin cap = {cap[4:0], sdata}; rise_n++; end
    if (le != 2'b00 && le_p == 2'b00) begin le_ev.push_back(le); le_cap.push_back(cap); end
    if ($countones(le) > 1 || $countones(le_b) > 1) bad_le++;
    if ((done && busy) || (done_b && busy_b)) bad_db++;
    sclk_p = sclk;
    le_p   = le;
    busy_nb += int'(busy_b);
    if (done_b) begin done_nb++; done_atb = ncyc; end
    if (sclk_b && !sclk_pb) begin
      capb = {capb[4:0], sdata_b};
      rise_nb++;
      rise_prev_b = rise_at_b;
      rise_at_b = ncyc;
    end
    if (le_b != 3'b000 && le_pb == 3'b000) le_ev_b.push_back(le_b);
    sclk_pb = sclk_b;
    le_pb   = le_b;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int wr_k, wr_kb;

  task automatic wr_a(input logic ch, input logic [5:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    wr_k = ncyc + 1;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic wr_b(input logic [1:0] ch, input logic [5:0] d);
    wr_en_b = 1'b1; wr_ch_b = ch; wr_data_b = d;
    wr_kb = ncyc + 1;
    cyc(1);
    wr_en_b = 1'b0;
  endtask

  int b_busy, b_done, b_le0, b_le1, b_rise, b_ev;

  task automatic snap();
    b_busy = busy_n; b_done = done_n; b_le0 = le0_n; b_le1 = le1_n;
    b_rise = rise_n; b_ev = le_ev.size();
  endtask

  initial begin
    nrst = 1'b0; nrst_b = 1'b0;
    wr_en_b = 1'b0; wr_ch_b = '0; wr_data_b = '0;
    repeat (2) begin
      wr_en = 1'($urandom); wr_ch = 1'($urandom); wr_data = 6'($urandom);
      cyc(1);
    end
    check("reset_outs", int'({sclk, sdata, le, busy, done}), 0);
    check("reset_outs_b", int'({sclk_b, sdata_b, le_b, busy_b, done_b}), 0);
    wr_en = 1'b0; nrst = 1'b1; nrst_b = 1'b1;
    cyc(5);
    check("idle_after_reset", busy_n + le_ev.size() + done_n, 0);

    // Single load of ch0 = 0x05, inverted on the wire.
    snap();
    wr_a(1'b0, 6'h05);
    cyc(35);
    check("t2_bits", int'(cap), 'h3A);
    check("t2_rises", rise_n - b_rise, 6);
    check("t2_le0_cycles", le0_n - b_le0, 2);
    check("t2_le1_cycles", le1_n - b_le1, 0);
    check("t2_busy_cycles", busy_n - b_busy, 27);
    check("t2_done_count", done_n - b_done, 1);
    check("t2_done_latency", done_at - wr_k - 1, 28);

    // Back-to-back writes: ch0 must go first despite being written second.
    snap();
    wr_a(1'b1, 6'h3F);
    wr_a(1'b0, 6'h00);
    cyc(70);
    check("t3_events", le_ev.size() - b_ev, 2);
    check("t3_done_count", done_n - b_done, 2);
    check("t3_first_le", int'(le_ev[b_ev]), 'b01);
    check("t3_first_bits", int'(le_cap[b_ev]), 'h3F);
    check("t3_second_le", int'(le_ev[b_ev+1]), 'b10);
    check("t3_second_bits", int'(le_cap[b_ev+1]), 'h00);

    // Rewrites during the shift must not disturb it; one reload with the latest value.
    snap();
    wr_a(1'b0, 6'h0C);
    cyc(6);
    wr_a(1'b0, 6'h10);
    wr_a(1'b0, 6'h11);
    cyc(70);
    check("t4_events", le_ev.size() - b_ev, 2);
    check("t4_done_count", done_n - b_done, 2);
    check("t4_first_bits", int'(le_cap[b_ev]), 'h33);
    check("t4_second_le", int'(le_ev[b_ev+1]), 'b01);
    check("t4_second_bits", int'(le_cap[b_ev+1]), 'h2E);

    // Reset in the middle of bit 3 with another channel queued.
    wr_a(1'b1, 6'h15);
    cyc(4);
    wr_a(1'b0, 6'h01);
    cyc(8);
    check("t5_busy_before", int'(busy), 1);
    nrst = 1'b0;
    cyc(1);
    check("t5_reset_outs", int'({sclk, sdata, le, busy, done}), 0);
    nrst = 1'b1;
    snap();
    cyc(60);
    check("t5_no_reload", (le_ev.size() - b_ev) + (done_n - b_done) + (busy_n - b_busy), 0);

    // Out-of-range channel on the 3-channel build is ignored.
    wr_b(2'd3, 6'h2A);
    cyc(20);
    check("t6_ignored", busy_nb + done_nb + le_ev_b.size(), 0);

    // Non-inverted, CLK_DIV=1 load.
    wr_b(2'd0, 6'h2A);
    cyc(30);
    check("t6_bits", int'(capb), 'h2A);
    check("t6_rises", rise_nb, 6);
    check("t6_sclk_period", rise_at_b - rise_prev_b, 2);
    check("t6_le", (le_ev_b.size() == 1) ? int'(le_ev_b[0]) : -1, 'b001);
    check("t6_done_latency", done_atb - wr_kb - 1, 16);
    check("t6_busy_cycles", busy_nb, 15);

    check("one_hot_le", bad_le, 0);
    check("done_vs_busy", bad_db, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
